// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the IFU/LSU memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_e;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IFU, LSU and shared-memory signals of the arbiter.
interface mem_port_arbiter_if;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  ifu_req_i, ifu_addr_i, lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output ifu_req_i, ifu_addr_i, lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: LSU-first winner selection with an IFU anti-starvation counter.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle,
  input  logic ifu_req,
  input  logic lsu_req,
  output logic ifu_win,
  output logic lsu_win
);
  logic [3:0] wait_cnt;
  logic       starved;
  always_comb begin
    starved = ifu_req && wait_cnt == 4'(STARVE_LIMIT);
    lsu_win = idle && lsu_req && !starved;
    ifu_win = idle && ifu_req && !lsu_win;
  end
  // Counts LSU wins that overtook a waiting IFU; any IDLE cycle without an IFU request restarts it.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wait_cnt <= '0;
    else if (idle)
      wait_cnt <= (ifu_win || !ifu_req) ? '0 :
                  (lsu_win && !starved) ? wait_cnt + 4'd1 : wait_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between IFU and LSU.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                clk_i,
  input logic                rst_ni,
  mem_port_arbiter_if.slave  bus
);
  arb_state_e  state, state_nx;
  arb_owner_e  owner;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        we, idle, ifu_win, lsu_win, done, ifu_done, lsu_done;
  // Grants are combinational, so gate them with reset to keep outputs low while held in reset.
  assign idle = rst_ni && state == IDLE;
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .idle    (idle),
    .ifu_req (bus.ifu_req_i),
    .lsu_req (bus.lsu_req_i),
    .ifu_win (ifu_win),
    .lsu_win (lsu_win)
  );
  always_comb begin
    done     = state == RSP && bus.mem_rvalid_i;
    ifu_done = done && owner == OWN_IFU;
    lsu_done = done && owner == OWN_LSU;
    state_nx = (ifu_win || lsu_win)           ? REQ  :
               (state == REQ && bus.mem_gnt_i) ? RSP  :
               done                            ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      owner <= OWN_IFU;
      addr  <= '0;
      we    <= 1'b0;
      be    <= '0;
      wdata <= '0;
    end else if (ifu_win || lsu_win) begin
      owner <= lsu_win ? OWN_LSU : OWN_IFU;
      addr  <= (lsu_win ? bus.lsu_addr_i : bus.ifu_addr_i) & ~32'h3;
      we    <= lsu_win && bus.lsu_we_i;
      be    <= lsu_win ? bus.lsu_be_i : 4'hF;
      wdata <= lsu_win ? bus.lsu_wdata_i : '0;
    end
  assign bus.ifu_gnt_o    = ifu_win;
  assign bus.lsu_gnt_o    = lsu_win;
  assign bus.mem_req_o    = state == REQ;
  assign bus.mem_we_o     = we;
  assign bus.mem_be_o     = be;
  assign bus.mem_addr_o   = addr;
  assign bus.mem_wdata_o  = wdata;
  assign bus.ifu_rvalid_o = ifu_done;
  assign bus.lsu_rvalid_o = lsu_done;
  assign bus.ifu_rdata_o  = ifu_done ? bus.mem_rdata_i : '0;
  assign bus.lsu_rdata_o  = lsu_done ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  task automatic clear_inputs();
    bus.ifu_req_i = 0; bus.ifu_addr_i = 0;
    bus.lsu_req_i = 0; bus.lsu_we_i = 0; bus.lsu_be_i = 0; bus.lsu_addr_i = 0; bus.lsu_wdata_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst_n = 0;
    bus.ifu_req_i = 1; bus.lsu_req_i = 1; bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1;
    sample();
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
         bus.mem_wdata_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rdata_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero while in reset (gnt %b%b req %b)",
                         bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_req_o);
    end
    tick();
    rst_n = 1; clear_inputs();
    sample();
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_req_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o} !== 5'b0) begin
      errors++; $display("FAIL reset_idle: got %b want 00000",
                         {bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_req_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o});
    end
    tick();
  endtask

  task automatic test_ifu_read();
    bus.ifu_req_i = 1; bus.ifu_addr_i = 32'h0000_0013; bus.mem_gnt_i = 1;
    sample();
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL ifu_read_gnt: got %b want 10", {bus.ifu_gnt_o, bus.lsu_gnt_o});
    end
    tick();
    bus.ifu_req_i = 0;
    sample();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h10, 32'h0}) begin
      errors++; $display("FAIL ifu_read_mem: req %b we %b be %h addr %h wdata %h want 1 0 f 00000010 00000000",
                         bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    tick();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEAD_BEEF;
    sample();
    checks++;
    if ({bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL ifu_read_rsp: rvalid %b%b rdata %h want 10 deadbeef",
                         bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o);
    end
    tick();
    clear_inputs();
    sample();
    checks++;
    if ({bus.ifu_rvalid_o, bus.mem_req_o} !== 2'b00) begin
      errors++; $display("FAIL ifu_read_after: rvalid %b req %b want 0 0", bus.ifu_rvalid_o, bus.mem_req_o);
    end
    tick();
  endtask

  task automatic test_lsu_store();
    int nl = 0, ni = 0;
    bus.lsu_req_i = 1; bus.lsu_we_i = 1; bus.lsu_be_i = 4'b0011;
    bus.lsu_addr_i = 32'h100; bus.lsu_wdata_i = 32'h1234_5678;
    sample();
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL store_gnt: got %b want 01", {bus.ifu_gnt_o, bus.lsu_gnt_o});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        bus.lsu_req_i = 0; bus.lsu_we_i = 0; bus.lsu_be_i = 4'($urandom);
        bus.lsu_addr_i = $urandom; bus.lsu_wdata_i = $urandom;
      end
      bus.mem_gnt_i = (k == 3);
      sample();
      nl += int'(bus.lsu_rvalid_o); ni += int'(bus.ifu_rvalid_o);
      checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678}) begin
        errors++; $display("FAIL store_stable[%0d]: req %b we %b be %h addr %h wdata %h want 1 1 3 00000100 12345678",
                           k, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
      end
    end
    tick();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h5555_AAAA;
    sample();
    nl += int'(bus.lsu_rvalid_o); ni += int'(bus.ifu_rvalid_o);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.mem_rvalid_i = 0;
      sample();
      nl += int'(bus.lsu_rvalid_o); ni += int'(bus.ifu_rvalid_o);
    end
    checks++;
    if (nl != 1 || ni != 0) begin
      errors++; $display("FAIL store_ack_count: lsu %0d ifu %0d want 1 0", nl, ni);
    end
    tick();
  endtask

  task automatic test_starvation();
    int n = 0, cyc = 0;
    bus.ifu_req_i = 1; bus.ifu_addr_i = $urandom;
    bus.lsu_req_i = 1; bus.lsu_we_i = 0; bus.lsu_be_i = 4'hF; bus.lsu_addr_i = $urandom;
    bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = $urandom;
    while (n < 10 && cyc < 60) begin
      sample();
      if (bus.ifu_gnt_o && bus.lsu_gnt_o) begin
        checks++; errors++; $display("FAIL starve_both_gnt: both grants high in cycle %0d", cyc);
      end else if (bus.ifu_gnt_o || bus.lsu_gnt_o) begin
        checks++;
        if (bus.lsu_gnt_o !== (n % 5 != 4)) begin
          errors++; $display("FAIL starve_order[%0d]: lsu_gnt %b want %b", n, bus.lsu_gnt_o, n % 5 != 4);
        end
        n++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL starve_timeout: saw %0d grants want 10", n);
    end
    bus.ifu_req_i = 0; bus.lsu_req_i = 0;
    repeat (3) tick();
    clear_inputs();
  endtask

  task automatic test_both();
    bus.ifu_req_i = 1; bus.ifu_addr_i = 32'h200; bus.lsu_req_i = 1; bus.lsu_addr_i = 32'h300; bus.mem_gnt_i = 1;
    sample();
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL both_first: gnt %b want 01", {bus.ifu_gnt_o, bus.lsu_gnt_o});
    end
    tick();
    bus.lsu_req_i = 0;
    sample();
    checks++;
    if (bus.ifu_gnt_o !== 1'b0) begin
      errors++; $display("FAIL both_req_phase: ifu_gnt %b want 0", bus.ifu_gnt_o);
    end
    tick();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0BAD_F00D;
    sample();
    checks++;
    if ({bus.lsu_rvalid_o, bus.ifu_gnt_o, bus.lsu_rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL both_rsp: lsu_rvalid %b ifu_gnt %b rdata %h want 1 0 0badf00d",
                         bus.lsu_rvalid_o, bus.ifu_gnt_o, bus.lsu_rdata_o);
    end
    tick();
    bus.mem_rvalid_i = 0;
    sample();
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL both_second: gnt %b want 10", {bus.ifu_gnt_o, bus.lsu_gnt_o});
    end
    tick();
    bus.ifu_req_i = 0;
    sample();
    checks++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL both_ifu_mem: req %b addr %h want 1 00000200", bus.mem_req_o, bus.mem_addr_o);
    end
    tick();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h7777_1111;
    sample();
    checks++;
    if ({bus.ifu_rvalid_o, bus.ifu_rdata_o} !== {1'b1, 32'h7777_1111}) begin
      errors++; $display("FAIL both_ifu_rsp: rvalid %b rdata %h want 1 77771111", bus.ifu_rvalid_o, bus.ifu_rdata_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bus.ifu_req_i = 1; bus.ifu_addr_i = 32'h40; bus.mem_gnt_i = 1;
    tick();
    bus.ifu_req_i = 0;
    tick();
    bus.mem_gnt_i = 0;
    rst_n = 0;
    #1;
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
         bus.mem_wdata_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o} !== '0) begin
      errors++; $display("FAIL reset_mid_async: req %b be %h addr %h want all 0",
                         bus.mem_req_o, bus.mem_be_o, bus.mem_addr_o);
    end
    tick();
    rst_n = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1357_9BDF;
    sample();
    checks++;
    if ({bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.mem_req_o} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_late_rvalid: rvalid %b%b req %b want 000",
                         bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.mem_req_o);
    end
    tick();
    bus.mem_rvalid_i = 0; bus.ifu_req_i = 1; bus.ifu_addr_i = 32'h46; bus.mem_gnt_i = 1;
    sample();
    checks++;
    if (bus.ifu_gnt_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_regnt: ifu_gnt %b want 1", bus.ifu_gnt_o);
    end
    tick();
    bus.ifu_req_i = 0;
    sample();
    checks++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h44}) begin
      errors++; $display("FAIL reset_mid_mem: req %b addr %h want 1 00000044", bus.mem_req_o, bus.mem_addr_o);
    end
    tick();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFE_F00D;
    sample();
    checks++;
    if ({bus.ifu_rvalid_o, bus.ifu_rdata_o} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL reset_mid_read: rvalid %b rdata %h want 1 cafef00d", bus.ifu_rvalid_o, bus.ifu_rdata_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_stray_rvalid();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFFFF_0000;
    repeat (2) begin
      sample();
      checks++;
      if ({bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.mem_req_o} !== 3'b000) begin
        errors++; $display("FAIL stray_idle: rvalid %b%b req %b want 000", bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.mem_req_o);
      end
      tick();
    end
    bus.ifu_req_i = 1; bus.ifu_addr_i = 32'h80;
    tick();
    bus.ifu_req_i = 0;
    repeat (2) begin
      sample();
      checks++;
      if ({bus.mem_req_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o} !== 3'b100) begin
        errors++; $display("FAIL stray_req: req %b rvalid %b%b want 100", bus.mem_req_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o);
      end
      tick();
    end
    bus.mem_rvalid_i = 0; bus.mem_gnt_i = 1;
    tick();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h2468_ACE0;
    sample();
    checks++;
    if ({bus.ifu_rvalid_o, bus.ifu_rdata_o} !== {1'b1, 32'h2468_ACE0}) begin
      errors++; $display("FAIL stray_complete: rvalid %b rdata %h want 1 2468ace0", bus.ifu_rvalid_o, bus.ifu_rdata_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    bit ip = 0, lp = 0, g_i = 0, g_l = 0, busy = 0, acc = 0, t_lsu = 0, e_i, e_l, e_rv;
    int streak = 0;
    logic [31:0] t_addr = 0, t_wdata = 0, got;
    logic [3:0]  t_be = 0;
    logic        t_we = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (g_i) ip = 0;
      if (g_l) lp = 0;
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; bus.ifu_addr_i = $urandom; end
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1; bus.lsu_addr_i = $urandom; bus.lsu_wdata_i = $urandom;
        bus.lsu_we_i = 1'($urandom); bus.lsu_be_i = 4'($urandom);
      end
      bus.ifu_req_i = ip; bus.lsu_req_i = lp;
      bus.mem_gnt_i = 1'($urandom); bus.mem_rvalid_i = 1'($urandom); bus.mem_rdata_i = $urandom;
      sample();
      e_l = !busy && lp && !(ip && streak == LIMIT);
      e_i = !busy && ip && !e_l;
      e_rv = busy && acc && bus.mem_rvalid_i;
      checks++;
      if ({bus.ifu_gnt_o, bus.lsu_gnt_o} !== {e_i, e_l}) begin
        errors++; $display("FAIL rand_gnt @%0d: got %b want %b%b", c, {bus.ifu_gnt_o, bus.lsu_gnt_o}, e_i, e_l);
      end
      checks++;
      if (bus.mem_req_o !== (busy && !acc)) begin
        errors++; $display("FAIL rand_mem_req @%0d: got %b want %b", c, bus.mem_req_o, busy && !acc);
      end
      if (busy && !acc) begin
        checks++;
        if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {t_we, t_be, t_addr, t_wdata}) begin
          errors++; $display("FAIL rand_mem_fields @%0d: we %b be %h addr %h wdata %h want %b %h %h %h", c,
                             bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o, t_we, t_be, t_addr, t_wdata);
        end
      end
      checks++;
      if ({bus.ifu_rvalid_o, bus.lsu_rvalid_o} !== {e_rv && !t_lsu, e_rv && t_lsu}) begin
        errors++; $display("FAIL rand_rvalid @%0d: got %b%b want %b%b", c, bus.ifu_rvalid_o, bus.lsu_rvalid_o,
                           e_rv && !t_lsu, e_rv && t_lsu);
      end
      if (e_rv && !(t_lsu && t_we)) begin
        got = t_lsu ? bus.lsu_rdata_o : bus.ifu_rdata_o;
        checks++;
        if (got !== bus.mem_rdata_i) begin
          errors++; $display("FAIL rand_rdata @%0d: got %h want %h", c, got, bus.mem_rdata_i);
        end
      end
      if (e_rv) busy = 0;
      else if (busy && !acc && bus.mem_gnt_i) acc = 1;
      else if (e_i || e_l) begin
        busy = 1; acc = 0; t_lsu = e_l;
        t_addr  = (e_l ? bus.lsu_addr_i : bus.ifu_addr_i) & ~32'h3;
        t_we    = e_l && bus.lsu_we_i;
        t_be    = e_l ? bus.lsu_be_i : 4'hF;
        t_wdata = e_l ? bus.lsu_wdata_i : 32'h0;
        streak  = (e_l && ip) ? streak + 1 : 0;
      end else if (!busy && !ip) streak = 0;
      g_i = e_i; g_l = e_l;
    end
    tick();
    bus.ifu_req_i = 0; bus.lsu_req_i = 0; bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1;
    repeat (3) tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_starvation();
    test_both();
    test_reset_mid();
    test_stray_rvalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..15: consecutive LSU wins tolerated while IFU waits.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_ni  in  1  one clock; reset is asynchronous and active-low.
REQ-004 ifu_req_i  in  1  fetch request, held until ifu_gnt_o.
REQ-005 ifu_addr_i  in  32  fetch byte address.
REQ-006 ifu_gnt_o  out  1  fetch request captured (1-cycle pulse).
REQ-007 ifu_rvalid_o / ifu_rdata_o  out  1 / 32  fetch data valid, fetch data.
REQ-008 lsu_req_i, lsu_we_i, lsu_be_i  in  1, 1, 4  data request, write enable, byte enables.
REQ-009 lsu_addr_i, lsu_wdata_i  in  32, 32  data byte address, write data.
REQ-010 lsu_gnt_o  out  1  data request captured (1-cycle pulse).
REQ-011 lsu_rvalid_o / lsu_rdata_o  out  1 / 32  load data or store ack valid, load data.
REQ-012 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1, 1, 4, 32, 32  shared memory request.
REQ-013 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1, 1, 32  memory accept, response valid, read data.

Function
REQ-014 FSM states IDLE, REQ, RSP; exactly one transaction outstanding at a time.
REQ-015 IDLE with any request: select winner, assert its gnt_o combinationally that cycle, latch address/we/be/wdata/owner, go REQ next cycle.
REQ-016 Arbitration: LSU wins over IFU, except when wait_cnt == STARVE_LIMIT and ifu_req_i=1, then IFU wins.
REQ-017 wait_cnt (4 bit): +1 when LSU granted while ifu_req_i=1, saturating at STARVE_LIMIT; cleared when IFU granted or when ifu_req_i=0 in IDLE.
REQ-018 IFU transactions: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-019 mem_addr_o = latched address with bits [1:0] forced to 0.
REQ-020 REQ: mem_req_o=1 with all mem_* fields stable until mem_gnt_i=1; then go RSP.
REQ-021 RSP: on mem_rvalid_i=1, owner's rvalid_o=1 and rdata_o=mem_rdata_i in the same cycle (combinational); go IDLE.
REQ-022 Stores also complete via mem_rvalid_i; lsu_rvalid_o pulses as store ack, lsu_rdata_o don't-care.
REQ-023 No new grant in the cycle mem_rvalid_i completes; earliest next grant is the following IDLE cycle.
REQ-024 Minimum latency: req at cycle 0, gnt_o cycle 0, mem_req_o cycle 1, rvalid_o cycle 2 (mem_gnt_i at 1, mem_rvalid_i at 2).
REQ-025 mem_rvalid_i outside RSP is ignored; non-owner rvalid_o always 0.
REQ-026 Requests deasserted after gnt_o do not affect the in-flight transaction.
REQ-027 Simultaneous ifu_req_i and lsu_req_i in IDLE: exactly one gnt_o pulses; the loser sees no gnt_o.

Reset
REQ-028 rst_ni low at any time, including mid-transaction: state IDLE, wait_cnt 0, latched fields 0, all outputs 0 immediately.
REQ-029 In-flight transaction aborted by reset produces no rvalid_o after reset release; a late mem_rvalid_i is ignored.

Structure
REQ-030 Shared package mem_arb_pkg: arb_state_e {IDLE, REQ, RSP}, arb_owner_e {OWN_IFU, OWN_LSU}, default STARVE_LIMIT constant.
REQ-031 One sub-module mem_arb_prio: wait_cnt plus winner selection; FSM and datapath latches stay in top.

Verification
REQ-032 Single IFU read addr 0x0000_0013, mem_gnt_i immediate, mem_rvalid_i next cycle data 0xDEAD_BEEF -> ifu_rvalid_o cycle 2, rdata 0xDEAD_BEEF, mem_addr_o 0x0000_0010.
REQ-033 LSU store addr 0x100, be 4'b0011, wdata 0x1234_5678, mem_gnt_i delayed 3 cycles -> mem_* stable 4 cycles, lsu_rvalid_o once, ifu_rvalid_o never.
REQ-034 ifu_req_i and lsu_req_i held high continuously, STARVE_LIMIT=4 -> grant order LSU x4, IFU, LSU x4, IFU.
REQ-035 Both request in same IDLE cycle, wait_cnt 0 -> only lsu_gnt_o pulses; IFU granted first IDLE after LSU response.
REQ-036 rst_ni low in RSP, mem_rvalid_i arrives after release -> all outputs 0, no rvalid_o, next IFU read completes normally.
REQ-037 mem_rvalid_i pulsed in IDLE and REQ -> no rvalid_o, FSM state unchanged.
